// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline registers
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W      = 5,
  parameter int REDIRECT_CYCLES = 1,
  parameter int TIMEOUT         = 64,
  parameter int STALL_CNT_W     = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   id_valid_i,
  input  logic [REG_ADDR_W-1:0]  id_rs1_i,
  input  logic [REG_ADDR_W-1:0]  id_rs2_i,
  input  logic                   id_use_rs1_i,
  input  logic                   id_use_rs2_i,
  input  logic                   ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0]  ex_rd_i,
  input  logic                   ex_branch_taken_i,
  input  logic                   dmem_busy_i,
  output logic                   pc_en_o,
  output logic                   ifid_en_o,
  output logic                   idex_en_o,
  output logic                   exmem_en_o,
  output logic                   memwb_en_o,
  output logic                   ifid_flush_o,
  output logic                   idex_flush_o,
  output logic                   exmem_flush_o,
  output logic                   memwb_flush_o,
  output logic [1:0]             state_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   err_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    REDIRECT = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  localparam int BUSY_MAX = (TIMEOUT == 0) ? 1 : TIMEOUT;
  localparam int BUSY_W   = $clog2(BUSY_MAX + 1);
  localparam logic [BUSY_W-1:0] BUSY_TOP  = BUSY_W'(BUSY_MAX);
  localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BUSY_MAX - 1);
  localparam logic [2:0] REDIR_LOAD = 3'(REDIRECT_CYCLES - 1);

  state_t                 r_state;
  state_t                 r_resume;
  logic [2:0]             r_redir_cnt;
  logic [BUSY_W-1:0]      r_busy_cnt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   r_err;

  state_t     w_next_state;
  state_t     w_next_resume;
  state_t     w_eff_state;
  logic [2:0] w_next_redir;
  logic       w_lu;

  assign w_lu = id_valid_i & ex_mem_read_i & (ex_rd_i != '0) &
                ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                 (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

  // Once memory frees up, MEM_WAIT behaves exactly like the state it interrupted.
  assign w_eff_state = (r_state == MEM_WAIT) ? r_resume : r_state;

  always_comb begin
    pc_en_o       = 1'b1;
    ifid_en_o     = 1'b1;
    idex_en_o     = 1'b1;
    exmem_en_o    = 1'b1;
    memwb_en_o    = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    memwb_flush_o = 1'b0;
    w_next_state  = RUN;
    w_next_resume = r_resume;
    w_next_redir  = r_redir_cnt;

    if (dmem_busy_i) begin
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_en_o     = 1'b0;
      exmem_en_o    = 1'b0;
      memwb_flush_o = 1'b1;
      w_next_state  = MEM_WAIT;
      w_next_resume = w_eff_state;
    end else if (ex_branch_taken_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      w_next_redir = REDIR_LOAD;
      w_next_state = (REDIRECT_CYCLES > 1) ? REDIRECT : RUN;
    end else if (w_eff_state == REDIRECT) begin
      ifid_flush_o = 1'b1;
      w_next_redir = r_redir_cnt - 3'd1;
      w_next_state = (r_redir_cnt == 3'd1) ? RUN : REDIRECT;
    end else if (w_lu) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_flush_o = 1'b1;
      w_next_state = LU_STALL;
    end

    // Reset forces a full freeze-and-bubble regardless of anything else.
    if (reset_i) begin
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_en_o     = 1'b0;
      exmem_en_o    = 1'b0;
      memwb_en_o    = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
      memwb_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= RUN;
      r_resume    <= RUN;
      r_redir_cnt <= 3'd0;
    end else begin
      r_state     <= w_next_state;
      r_resume    <= w_next_resume;
      r_redir_cnt <= w_next_redir;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_busy_cnt  <= '0;
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (!pc_en_o && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (dmem_busy_i) begin
        if (r_busy_cnt != BUSY_TOP) begin
          r_busy_cnt <= r_busy_cnt + 1'b1;
        end
        if ((TIMEOUT != 0) && (r_busy_cnt == BUSY_LAST)) begin
          r_err <= 1'b1;
        end
      end else begin
        r_busy_cnt <= '0;
      end
    end
  end

  assign state_o     = r_state;
  assign stall_cnt_o = r_stall_cnt;
  assign err_o       = r_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       id_valid_i;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic       id_use_rs1_i;
  logic       id_use_rs2_i;
  logic       ex_mem_read_i;
  logic [4:0] ex_rd_i;
  logic       ex_branch_taken_i;
  logic       dmem_busy_i;
  logic       pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o;
  logic       ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o;
  logic [1:0] state_o;
  logic [15:0] stall_cnt_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(5),
    .REDIRECT_CYCLES(3),
    .TIMEOUT(8),
    .STALL_CNT_W(16)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i),
    .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i),
    .id_use_rs2_i(id_use_rs2_i),
    .ex_mem_read_i(ex_mem_read_i),
    .ex_rd_i(ex_rd_i),
    .ex_branch_taken_i(ex_branch_taken_i),
    .dmem_busy_i(dmem_busy_i),
    .pc_en_o(pc_en_o),
    .ifid_en_o(ifid_en_o),
    .idex_en_o(idex_en_o),
    .exmem_en_o(exmem_en_o),
    .memwb_en_o(memwb_en_o),
    .ifid_flush_o(ifid_flush_o),
    .idex_flush_o(idex_flush_o),
    .exmem_flush_o(exmem_flush_o),
    .memwb_flush_o(memwb_flush_o),
    .state_o(state_o),
    .stall_cnt_o(stall_cnt_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid_i        = 1'b0;
    id_rs1_i          = 5'd0;
    id_rs2_i          = 5'd0;
    id_use_rs1_i      = 1'b0;
    id_use_rs2_i      = 1'b0;
    ex_mem_read_i     = 1'b0;
    ex_rd_i           = 5'd0;
    ex_branch_taken_i = 1'b0;
    dmem_busy_i       = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
  endtask

  initial begin
    clear_inputs();
    reset_i = 1'b1;
    #2;
    check("rst_pc_en", pc_en_o, 0);
    check("rst_memwb_en", memwb_en_o, 0);
    check("rst_ifid_flush", ifid_flush_o, 1);
    check("rst_exmem_flush", exmem_flush_o, 1);
    tick();
    reset_i = 1'b0;
    #1;
    check("rst_state", state_o, 0);
    check("rst_stall", stall_cnt_o, 0);
    check("rst_err", err_o, 0);
    check("idle_pc_en", pc_en_o, 1);
    check("idle_ifid_flush", ifid_flush_o, 0);

    // Load-use on rs2
    id_valid_i = 1'b1; ex_mem_read_i = 1'b1; ex_rd_i = 5'd5;
    id_use_rs2_i = 1'b1; id_rs2_i = 5'd5; id_use_rs1_i = 1'b1; id_rs1_i = 5'd3;
    #1;
    check("lu_pc_en", pc_en_o, 0);
    check("lu_ifid_en", ifid_en_o, 0);
    check("lu_idex_flush", idex_flush_o, 1);
    check("lu_idex_en", idex_en_o, 1);
    tick();
    ex_mem_read_i = 1'b0;
    #1;
    check("lu_state", state_o, 1);
    check("lu_stall_cnt", stall_cnt_o, 1);
    check("lu_release_pc_en", pc_en_o, 1);
    tick();
    check("lu_back_run", state_o, 0);

    // ex_rd == 0 never stalls
    ex_mem_read_i = 1'b1; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_use_rs1_i = 1'b1;
    #1;
    check("rd0_pc_en", pc_en_o, 1);
    check("rd0_ifid_en", ifid_en_o, 1);
    tick();
    check("rd0_state", state_o, 0);

    // rs1 matches but is not used
    ex_rd_i = 5'd7; id_rs1_i = 5'd7; id_use_rs1_i = 1'b0; id_rs2_i = 5'd2; id_use_rs2_i = 1'b1;
    #1;
    check("nouse_pc_en", pc_en_o, 1);
    check("nouse_idex_flush", idex_flush_o, 0);
    tick();
    check("nouse_state", state_o, 0);

    // Squashed ID instruction never stalls
    id_valid_i = 1'b0; id_use_rs1_i = 1'b1;
    #1;
    check("invalid_pc_en", pc_en_o, 1);
    tick();
    check("nolu_stall_cnt", stall_cnt_o, 1);

    // Redirect over 3 cycles with load-use ignored after the branch cycle
    clear_inputs();
    ex_branch_taken_i = 1'b1;
    #1;
    check("br_ifid_flush", ifid_flush_o, 1);
    check("br_idex_flush", idex_flush_o, 1);
    check("br_pc_en", pc_en_o, 1);
    tick();
    ex_branch_taken_i = 1'b0;
    id_valid_i = 1'b1; ex_mem_read_i = 1'b1; ex_rd_i = 5'd9; id_rs1_i = 5'd9; id_use_rs1_i = 1'b1;
    #1;
    check("redir1_state", state_o, 2);
    check("redir1_ifid_flush", ifid_flush_o, 1);
    check("redir1_idex_flush", idex_flush_o, 0);
    check("redir1_pc_en", pc_en_o, 1);
    tick();
    check("redir2_state", state_o, 2);
    check("redir2_ifid_flush", ifid_flush_o, 1);
    check("redir2_pc_en", pc_en_o, 1);
    clear_inputs();
    tick();
    check("redir_done_state", state_o, 0);
    check("redir_done_flush", ifid_flush_o, 0);
    check("redir_stall_cnt", stall_cnt_o, 1);

    // Memory busy in the middle of a redirect
    do_reset();
    ex_branch_taken_i = 1'b1;
    tick();
    ex_branch_taken_i = 1'b0;
    dmem_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mw_pc_en", pc_en_o, 0);
      check("mw_exmem_en", exmem_en_o, 0);
      check("mw_memwb_en", memwb_en_o, 1);
      check("mw_memwb_flush", memwb_flush_o, 1);
      check("mw_ifid_flush", ifid_flush_o, 0);
      check("mw_state", state_o, (i == 0) ? 2 : 3);
      tick();
    end
    dmem_busy_i = 1'b0;
    #1;
    check("mw_after_state", state_o, 3);
    check("mw_stall_cnt", stall_cnt_o, 4);
    check("mw_resume_flush", ifid_flush_o, 1);
    check("mw_resume_pc_en", pc_en_o, 1);
    tick();
    check("mw_resume_state", state_o, 2);
    check("mw_resume_flush2", ifid_flush_o, 1);
    tick();
    check("mw_resume_end", state_o, 0);
    check("mw_resume_noflush", ifid_flush_o, 0);
    check("mw_err", err_o, 0);

    // Timeout after 8 consecutive busy cycles
    dmem_busy_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("to_err", err_o, (i >= 8) ? 1 : 0);
      tick();
    end
    dmem_busy_i = 1'b0;
    #1;
    check("to_err_sticky", err_o, 1);
    check("to_pc_en", pc_en_o, 1);
    tick();
    check("to_err_sticky2", err_o, 1);
    check("to_state", state_o, 0);

    // Asynchronous reset in MEM_WAIT
    dmem_busy_i = 1'b1;
    tick();
    check("ar_pre_state", state_o, 3);
    #1;
    reset_i = 1'b1;
    #1;
    check("ar_state", state_o, 0);
    check("ar_err", err_o, 0);
    check("ar_stall", stall_cnt_o, 0);
    check("ar_memwb_en", memwb_en_o, 0);
    check("ar_ifid_flush", ifid_flush_o, 1);
    dmem_busy_i = 1'b0;
    tick();
    reset_i = 1'b0;
    #1;
    check("ar_rel_state", state_o, 0);
    check("ar_rel_err", err_o, 0);
    check("ar_rel_stall", stall_cnt_o, 0);
    check("ar_rel_pc_en", pc_en_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline's PC and IF/ID, ID/EX, EX/MEM, MEM/WB pipeline registers.
- Detects load-use hazards, sequences taken-branch redirects over a configurable fetch latency, and freezes the pipeline while data memory is busy.
- Drives per-register enable and flush controls. Keeps a saturating stall-cycle counter and a sticky memory-timeout error.

Parameters:
- REG_ADDR_W, 5, width of register-file addresses.
- REDIRECT_CYCLES, 1, cycles IF/ID is flushed after a taken branch. Legal range 1..7.
- TIMEOUT, 64, consecutive dmem_busy_i cycles before err_o sets. 0 disables the timeout.
- STALL_CNT_W, 16, width of stall_cnt_o.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- id_valid_i  in  1  ID stage holds a real (unsquashed) instruction.
- id_rs1_i  in  REG_ADDR_W  ID source register 1.
- id_rs2_i  in  REG_ADDR_W  ID source register 2.
- id_use_rs1_i  in  1  ID instruction reads rs1.
- id_use_rs2_i  in  1  ID instruction reads rs2.
- ex_mem_read_i  in  1  EX instruction is a load.
- ex_rd_i  in  REG_ADDR_W  EX destination register.
- ex_branch_taken_i  in  1  EX resolved a taken branch or jump.
- dmem_busy_i  in  1  data memory cannot complete the MEM-stage access this cycle.
- pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o  out  1 each  register load enables.
- ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o  out  1 each  load a bubble instead of data.
- state_o  out  2  current FSM state.
- stall_cnt_o  out  STALL_CNT_W  cycles with pc_en_o=0; saturates at all-ones.
- err_o  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (asynchronous): state=RUN, redirect counter=0, resume state=RUN, busy counter=0, stall_cnt_o=0, err_o=0.
- While reset_i=1: all *_en_o=0 and all *_flush_o=1.
- Outputs are combinational from current state and inputs (zero latency). State and counters update on clk_i.
- States: RUN=0, LU_STALL=1, REDIRECT=2, MEM_WAIT=3.
- Load-use condition lu = id_valid_i & ex_mem_read_i & (ex_rd_i!=0) & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)).
- Default outputs: all enables=1, all flushes=0.
- Priority each cycle: dmem_busy_i > ex_branch_taken_i > redirect in progress > lu.
- dmem_busy_i=1, any state:
  - pc/ifid/idex/exmem enables=0; memwb_en_o=1, memwb_flush_o=1.
  - Entering MEM_WAIT from another state saves that state as resume state. The redirect counter is frozen.
  - Branch and load-use are ignored; EX inputs are held stable by the frozen ID/EX register.
- MEM_WAIT with dmem_busy_i=0: outputs and transitions are evaluated exactly as in the resume state.
- ex_branch_taken_i=1, not busy, any state:
  - ifid_flush_o=1, idex_flush_o=1; pc_en_o=1 loads the target.
  - Redirect counter loads REDIRECT_CYCLES-1.
  - Next state = REDIRECT if REDIRECT_CYCLES>1, else RUN.
  - A branch while in REDIRECT restarts the counter.
- REDIRECT, not busy, no branch:
  - ifid_flush_o=1 and lu is ignored; counter decrements.
  - When the counter is 1 at the clock edge, next state is RUN.
- lu=1 in RUN or LU_STALL, not busy, no branch:
  - pc_en_o=0, ifid_en_o=0, idex_flush_o=1; next state=LU_STALL.
- No event in RUN or LU_STALL: next state=RUN.
- stall_cnt_o increments on each clock edge where pc_en_o=0 and reset_i=0; it holds at the maximum value.
- Busy counter:
  - Increments while dmem_busy_i=1 and clears when dmem_busy_i=0.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT, err_o=1 until reset. err_o does not change the control outputs.
- Reset asserted mid-operation (MEM_WAIT or REDIRECT) aborts immediately. No resume state survives the reset.

Test Plan:
- Load-use: ex_mem_read_i=1, ex_rd_i=5, id_valid_i=1, id_use_rs2_i=1, id_rs2_i=5 for one cycle, then ex_mem_read_i=0 -> cycle 1 pc_en_o=0, ifid_en_o=0, idex_flush_o=1; state_o=1 at cycle 2; stall_cnt_o=1.
- Load-use with ex_rd_i=0, or with id_use_rs1_i=0 while id_rs1_i matches -> no stall; all enables=1, state_o stays 0.
- REDIRECT_CYCLES=3, branch pulse -> ifid_flush_o=1 for 3 cycles, idex_flush_o=1 on the first cycle only; state_o 2,2,then 0. A load-use match during cycles 2-3 is ignored.
- Branch, then dmem_busy_i=1 for 4 cycles in REDIRECT -> 4 cycles with pc..exmem enables=0 and memwb_flush_o=1, state_o=3. Afterwards REDIRECT resumes with the remaining flush count intact; stall_cnt_o=4.
- TIMEOUT=8, dmem_busy_i held 10 cycles -> err_o rises after the 8th busy cycle and stays 1 after busy drops until reset_i.
- reset_i asserted asynchronously mid-MEM_WAIT -> outputs go to reset values before the next clk_i edge; after release state_o=0, err_o=0, stall_cnt_o=0.
